// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - IITB-RISC opcode constants and LM/SM field positions
package isa_pkg;

  // Opcodes of the load/store multiple instructions (instr[15:12])
  localparam logic [3:0] OPC_LM = 4'b0110;
  localparam logic [3:0] OPC_SM = 4'b0111;

  // Instruction field positions
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RA_MSB   = 11;
  localparam int RA_LSB   = 9;
  localparam int MASK_MSB = 7;
  localparam int MASK_LSB = 0;

  // Index into the 8-entry register file
  typedef logic [2:0] reg_idx_t;

  // True for instructions that expand into one micro-op per mask bit
  function automatic logic is_multi(input logic [15:0] instr);
    return (instr[OPC_MSB:OPC_LSB] == OPC_LM) || (instr[OPC_MSB:OPC_LSB] == OPC_SM);
  endfunction

endpackage

// File: rtl/lsb_prio_enc8.sv
// rtl/lsb_prio_enc8.sv - lowest-set-bit priority encoder for an 8-bit register mask
module lsb_prio_enc8
  import isa_pkg::*;
(
  input  logic [7:0] mask_i,
  output reg_idx_t   idx_o,
  output logic [7:0] clr_o,
  output logic       any_o,
  output logic       one_o
);

  logic found;

  // Scan upward so the lowest set bit wins; R0 is emitted first
  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && mask_i[i]) begin
        idx_o = reg_idx_t'(i);
        found = 1'b1;
      end
    end
  end

  // Isolate the lowest set bit (mask & -mask) and flag a single remaining bit
  always_comb begin
    clr_o = mask_i & (~mask_i + 8'd1);
    any_o = |mask_i;
    one_o = any_o && ((mask_i & ~clr_o) == 8'd0);
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - expands LM/SM into per-register micro-ops, passes others through
module lm_sm_sequencer
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_in,
  input  logic        out_ready,
  output logic        uop_valid,
  output logic [15:0] uop_instr,
  output logic [15:0] uop_pc,
  output logic [2:0]  uop_reg,
  output logic [2:0]  uop_offset,
  output logic        uop_is_multi,
  output logic        uop_first,
  output logic        uop_last,
  output logic        busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEQ  = 1'b1;

  logic [0:0]  state_q,   state_d;
  logic [7:0]  pending_q, pending_d;
  logic        valid_q,   valid_d;
  logic [15:0] instr_q,   instr_d;
  logic [15:0] pc_q,      pc_d;
  reg_idx_t    reg_q,     reg_d;
  logic [2:0]  offset_q,  offset_d;
  logic        multi_q,   multi_d;
  logic        first_q,   first_d;
  logic        last_q,    last_d;

  logic        advance;
  logic        accept;
  logic [7:0]  enc_in;
  reg_idx_t    enc_idx;
  logic [7:0]  enc_clr;
  logic        enc_any;
  logic        enc_one;

  // Slot can take a new entry when empty or when downstream consumes it
  always_comb begin
    advance  = !valid_q || out_ready;
    in_ready = (state_q == ST_IDLE) && advance && !flush;
    accept   = in_valid && in_ready;
    // Sequencing walks the pending mask; otherwise look at the incoming mask
    enc_in   = (state_q == ST_SEQ) ? pending_q : instr_in[MASK_MSB:MASK_LSB];
  end

  lsb_prio_enc8 u_enc (
    .mask_i (enc_in),
    .idx_o  (enc_idx),
    .clr_o  (enc_clr),
    .any_o  (enc_any),
    .one_o  (enc_one)
  );

  // Next-state: flush squashes everything, SEQ emits the next register, IDLE accepts
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    reg_d     = reg_q;
    offset_d  = offset_q;
    multi_d   = multi_q;
    first_d   = first_q;
    last_d    = last_q;

    if (flush) begin
      valid_d   = 1'b0;
      state_d   = ST_IDLE;
      pending_d = 8'd0;
    end else if (state_q == ST_SEQ) begin
      if (advance) begin
        valid_d   = 1'b1;
        reg_d     = enc_idx;
        offset_d  = offset_q + 3'd1;
        first_d   = 1'b0;
        last_d    = enc_one;
        pending_d = pending_q & ~enc_clr;
        state_d   = enc_one ? ST_IDLE : ST_SEQ;
      end
    end else if (advance) begin
      // Slot drains unless something new is loaded below
      valid_d = 1'b0;
      if (accept) begin
        instr_d  = instr_in;
        pc_d     = pc_in;
        offset_d = 3'd0;
        first_d  = 1'b1;
        if (is_multi(instr_in)) begin
          // An empty mask is consumed without producing a micro-op
          if (enc_any) begin
            valid_d   = 1'b1;
            reg_d     = enc_idx;
            multi_d   = 1'b1;
            last_d    = enc_one;
            pending_d = instr_in[MASK_MSB:MASK_LSB] & ~enc_clr;
            state_d   = enc_one ? ST_IDLE : ST_SEQ;
          end
        end else begin
          valid_d = 1'b1;
          reg_d   = '0;
          multi_d = 1'b0;
          last_d  = 1'b1;
        end
      end
    end
  end

  // State and output slot registers; reset clears everything including outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 8'd0;
      valid_q   <= 1'b0;
      instr_q   <= 16'd0;
      pc_q      <= 16'd0;
      reg_q     <= '0;
      offset_q  <= 3'd0;
      multi_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      reg_q     <= reg_d;
      offset_q  <= offset_d;
      multi_q   <= multi_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  // Drive outputs straight from the slot
  always_comb begin
    uop_valid    = valid_q;
    uop_instr    = instr_q;
    uop_pc       = pc_q;
    uop_reg      = reg_q;
    uop_offset   = offset_q;
    uop_is_multi = multi_q;
    uop_first    = first_q;
    uop_last     = last_q;
    busy         = (state_q == ST_SEQ);
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - self-checking bench for lm_sm_sequencer
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instr_in = 16'd0;
  logic [15:0] pc_in = 16'd0;
  logic        out_ready = 1'b1;
  logic        uop_valid;
  logic [15:0] uop_instr;
  logic [15:0] uop_pc;
  logic [2:0]  uop_reg;
  logic [2:0]  uop_offset;
  logic        uop_is_multi;
  logic        uop_first;
  logic        uop_last;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  lm_sm_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr_in     (instr_in),
    .pc_in        (pc_in),
    .out_ready    (out_ready),
    .uop_valid    (uop_valid),
    .uop_instr    (uop_instr),
    .uop_pc       (uop_pc),
    .uop_reg      (uop_reg),
    .uop_offset   (uop_offset),
    .uop_is_multi (uop_is_multi),
    .uop_first    (uop_first),
    .uop_last     (uop_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  r;
    logic [2:0]  off;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        multi;
    logic        first;
    logic        last;
  } uop_t;

  // Expected micro-op stream of the instruction in flight; entry 0 is what the slot shows
  uop_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return !flush && (exp_q.size() <= 1) && (exp_q.size() == 0 || out_ready);
  endfunction

  task automatic expand(input logic [15:0] ins, input logic [15:0] p);
    uop_t u;
    int cnt;
    int rank;
    u.instr = ins;
    u.pc    = p;
    if (ins[15:12] == 4'b0110 || ins[15:12] == 4'b0111) begin
      cnt = $countones(ins[7:0]);
      rank = 0;
      for (int i = 0; i < 8; i++) begin
        if (ins[i]) begin
          u.r     = 3'(i);
          u.off   = 3'(rank);
          u.multi = 1'b1;
          u.first = (rank == 0);
          u.last  = (rank == cnt - 1);
          exp_q.push_back(u);
          rank++;
        end
      end
    end else begin
      u.r = 3'd0; u.off = 3'd0; u.multi = 1'b0; u.first = 1'b1; u.last = 1'b1;
      exp_q.push_back(u);
    end
  endtask

  task automatic check_model();
    chk("valid", uop_valid, exp_q.size() > 0);
    chk("in_ready", in_ready, model_ready());
    chk("busy", busy, exp_q.size() > 1);
    if (exp_q.size() > 0) begin
      chk("reg", uop_reg, exp_q[0].r);
      chk("offset", uop_offset, exp_q[0].off);
      chk("instr", uop_instr, exp_q[0].instr);
      chk("pc", uop_pc, exp_q[0].pc);
      chk("is_multi", uop_is_multi, exp_q[0].multi);
      chk("first", uop_first, exp_q[0].first);
      chk("last", uop_last, exp_q[0].last);
    end
  endtask

  // Advance one clock, update the model from pre-edge inputs, then compare
  task automatic tick();
    logic acc, rs, fl, orr;
    logic [15:0] ins, p;
    acc = in_valid && model_ready();
    rs  = reset;
    fl  = flush;
    orr = out_ready;
    ins = instr_in;
    p   = pc_in;
    @(posedge clk);
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && orr) void'(exp_q.pop_front());
      if (acc) expand(ins, p);
    end
    #1;
    check_model();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, uop_valid, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_instr"}, uop_instr, 0);
    chk({name, "_pc"}, uop_pc, 0);
    chk({name, "_reg"}, uop_reg, 0);
    chk({name, "_off"}, uop_offset, 0);
    chk({name, "_flags"}, {uop_is_multi, uop_first, uop_last}, 0);
  endtask

  logic [2:0] a5_regs [4] = '{3'd0, 3'd2, 3'd5, 3'd7};

  initial begin
    // Reset
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // Back-to-back pass-through
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_in = 16'h0123 + 16'(i);
      pc_in    = 16'h0010 + 16'(i);
      tick();
      chk("pt_pc", uop_pc, 16'h0010 + 16'(i));
      chk("pt_reg", uop_reg, 0);
      chk("pt_first_last", {uop_first, uop_last}, 2'b11);
      chk("pt_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();

    // LM with mask A5
    instr_in = 16'h66A5; pc_in = 16'h0020; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("a5_reg", uop_reg, a5_regs[k]);
      chk("a5_off", uop_offset, 3'(k));
      chk("a5_pc", uop_pc, 16'h0020);
      chk("a5_first", uop_first, k == 0);
      chk("a5_last", uop_last, k == 3);
      chk("a5_in_ready", in_ready, k == 3);
    end
    tick();

    // SM with mask 81 and a 3-cycle downstream stall
    instr_in = 16'h7281; pc_in = 16'h0030; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sm_hold_reg", uop_reg, 0);
      chk("sm_hold_valid", uop_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("sm_hold_off", uop_offset, 0);
    tick();
    chk("sm_r7_reg", uop_reg, 7);
    chk("sm_r7_off", uop_offset, 1);
    chk("sm_r7_last", uop_last, 1);
    tick();

    // LM with empty mask followed by a pass-through
    instr_in = 16'h6600; pc_in = 16'h0040; in_valid = 1'b1;
    tick();
    chk("lm0_valid", uop_valid, 0);
    instr_in = 16'h0A50; pc_in = 16'h0041;
    tick();
    chk("lm0_next_pc", uop_pc, 16'h0041);
    in_valid = 1'b0;
    tick();

    // Flush on the second micro-op of mask FF
    instr_in = 16'h6EFF; pc_in = 16'h0050; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ff_second_reg", uop_reg, 1);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_valid", uop_valid, 0);
    chk("flush_busy", busy, 0);
    flush = 1'b0;
    instr_in = 16'h0B00; pc_in = 16'h0060; in_valid = 1'b1;
    #1;
    chk("post_flush_ready", in_ready, 1);
    tick();
    chk("post_flush_pc", uop_pc, 16'h0060);
    in_valid = 1'b0;
    tick();

    // Reset in the middle of mask 3C
    instr_in = 16'h603C; pc_in = 16'h0070; in_valid = 1'b1;
    tick();
    chk("3c_first_reg", uop_reg, 2);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_reset_valid", uop_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Decode-side stage directly upstream of the 8x16 register file. Expands IITB-RISC LM/SM (load/store multiple) instructions into one micro-op per selected register.
- Supplies the register index that becomes the register file's read address (SM) or write address (LM), plus a memory word offset.
- All other instructions pass through unchanged with one cycle of latency.
- Stalls fetch/decode while a sequence is in progress.

Parameters:
- OPC_LM, 4'b0110, opcode value (instr[15:12]) for load multiple
- OPC_SM, 4'b0111, opcode value (instr[15:12]) for store multiple

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  squash pending and presented work (branch/jump redirect)
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  sequencer accepts instruction this cycle
- instr_in  input  16  instruction word; LM/SM: [11:9]=RA, [7:0]=register mask
- pc_in  input  16  PC of instr_in
- out_ready  input  1  downstream (register-read stage) can take a micro-op
- uop_valid  output  1  micro-op register holds valid entry
- uop_instr  output  16  original instruction word
- uop_pc  output  16  original PC (same for every micro-op of one LM/SM)
- uop_reg  output  3  register index for this micro-op; 0 for pass-through
- uop_offset  output  3  memory word offset from RA content (0,1,2,...)
- uop_is_multi  output  1  micro-op comes from LM/SM
- uop_first  output  1  first micro-op of an instruction (1 for pass-through)
- uop_last  output  1  last micro-op of an instruction (1 for pass-through)
- busy  output  1  state==SEQ

Behaviour:
- Single clock `clk`. Reset is synchronous, active-high, named `reset`.
- Reset: state=IDLE, pending mask=0, offset counter=0, all uop_* outputs=0, busy=0.
- Output slot is one register. advance = !uop_valid || out_ready.
- in_ready = (state==IDLE) && advance && !flush.
- accept = in_valid && in_ready.
- IDLE, accept, not LM/SM: at the next edge the slot loads the instruction with uop_reg=0, offset=0, is_multi=0, first=1, last=1. Throughput is one per cycle.
- IDLE, accept, LM/SM with mask!=0: the slot loads the lowest set bit i as uop_reg=i, offset=0, first=1.
  - pending = mask with bit i cleared.
  - If pending==0: last=1, remain in IDLE. Otherwise last=0 and go to SEQ.
- IDLE, accept, LM/SM with mask==0: the instruction is consumed and no micro-op is emitted. uop_valid=0 next cycle, unless another source reloads the slot.
- SEQ, each edge with advance:
  - Load the lowest set bit of pending, offset+1, first=0, and clear that bit.
  - When the cleared bit was the last one: last=1, state goes to IDLE.
  - Without advance, the slot and pending mask hold.
- Micro-op order is ascending register index (R0 first). Offset is the rank among set bits.
- Latency: instruction accepted at edge N. Micro-ops for k set bits are presented in cycles N+1..N+k when out_ready stays 1. in_ready=0 in cycles N+1..N+k-1 and returns to 1 in cycle N+k.
- R7 in the mask is emitted like any other register; the PC side effects belong to the register file and writeback.
- uop_* outputs hold stable while uop_valid && !out_ready.
- Flush has priority over accept and advance. At the next edge: uop_valid=0, state=IDLE, pending=0. in_ready=0 during the flush cycle.
- Reset has priority over flush. Reset mid-sequence abandons the sequence, and no further micro-ops are emitted.

Decomposition:
- Shared package (isa_pkg): OPC_LM/OPC_SM opcode constants, field positions for RA and mask, 3-bit register index type.
- One natural sub-module: lsb_prio_enc8. Combinational; 8-bit mask in, gives 3-bit index of lowest set bit, one-hot clear mask, and an "only one bit" flag.

Test Plan:
- Pass-through: ADD instrs at PC 0x0010..0x0013 back-to-back, out_ready=1 → uop_valid each cycle, uop_reg=0, first=last=1, in_ready stays 1.
- LM mask 8'hA5: uop_reg 0,2,5,7 with offsets 0,1,2,3 in 4 consecutive cycles. first only on R0, last only on R7, uop_pc constant. in_ready low for 3 cycles.
- SM mask 8'h81, out_ready=0 for 3 cycles after the first micro-op: R0/offset0 held stable 4 cycles, then R7/offset1 with last=1.
- LM mask 8'h00: consumed in 1 cycle, no uop_valid. The following ADD is presented next cycle.
- Flush in the cycle the second micro-op of mask 8'hFF is shown: uop_valid=0 next cycle, busy=0. A new instruction is accepted one cycle later.
- Reset asserted mid-sequence (mask 8'h3C, after R2): all outputs 0 next cycle. No R3..R5 micro-ops follow after reset deasserts.
